bounce_sprite_engine: RTL and testbench
=======================================

Name: bounce_sprite_engine

Overview:
Parametrised multi-sprite "bouncing tile" renderer for the TinyVGA output path. It is driven by `hvsync_generator` outputs: beam position, display enable and a one-cycle frame tick.
- Moves NUM_SPRITES independent tiles around a tile grid, one step per frame-divider period.
- Cycles each sprite's colour on every wall bounce and counts exact corner hits.
- Produces a registered 6-bit RGB pixel.
- Replaces vsync-clocked motion logic with fully synchronous single-clock logic.

Parameters:
- NUM_SPRITES, 2, number of sprites (1..8); lower index has display priority.
- TILE_LOG2, 5, tile edge = 2^TILE_LOG2 pixels.
- GRID_W, 20, tile columns; legal positions 0..GRID_W-1; GRID_W <= 2^(10-TILE_LOG2).
- GRID_H, 15, tile rows; legal positions 0..GRID_H-1; GRID_H <= 2^(10-TILE_LOG2).
- FRAME_DIV, 1, frame ticks per motion step (1..255).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per frame, generated at start of vertical blanking.
- pause  in  1  1 = freeze motion and frame divider.
- video_active  in  1  display-enable from `hvsync_generator`.
- pix_x  in  10  beam column.
- pix_y  in  10  beam row.
- fg_color  in  6  base sprite colour {R[1:0],G[1:0],B[1:0]}.
- bg_color  in  6  background colour.
- rgb  out  6  registered pixel colour.
- corner_hit  out  1  one-cycle pulse on a motion step in which some sprite bounces in x and y together.
- corner_count  out  8  saturating count of corner_hit pulses.

Behaviour:
- Reset: synchronous, dominates all other inputs including a coincident frame_tick.
- Values on reset:
  - Outputs: rgb=0, corner_hit=0, corner_count=0, frame divider=0.
  - Sprite i position: x=(GRID_W/2+3i) mod GRID_W, y=(GRID_H/2+5i) mod GRID_H.
  - Sprite i direction: dir_x=1 for even i, 0 for odd i; dir_y=1.
  - Sprite i hue: hue=i[2:0].
- Register widths: x is clog2(GRID_W) bits, y is clog2(GRID_H) bits, hue is 3 bits (wraps 7->0).
- Frame divider:
  - On frame_tick with pause=0, increment the divider.
  - When the divider equals FRAME_DIV-1, it returns to 0 and a step occurs in that same cycle.
  - pause=1 ignores frame_tick entirely; the divider holds its value.
- Step, per sprite, per axis (x shown; y is identical using GRID_H):
  - dir=1 and x==GRID_W-1: dir<=0, x unchanged (bounce).
  - dir=0 and x==0: dir<=1, x unchanged (bounce).
  - Otherwise x<=x+1 if dir=1, else x<=x-1.
- Hue: incremented once per step if the sprite bounced on x, y or both.
- Corner detection:
  - A sprite bouncing on both axes in the same step is a corner.
  - corner_hit=1 for exactly the cycle after the step if any sprite cornered, else 0.
  - corner_count increments by 1 per such step, regardless of how many sprites cornered; it saturates at 255.
- Sprite colour i = fg_color XOR {hue_i,hue_i}.
- Pixel path (combinational hit test, registered output):
  - Tile coordinates: tx=pix_x>>TILE_LOG2, ty=pix_y>>TILE_LOG2.
  - Sprite i hits when tx==x_i and ty==y_i; unused high bits are zero-extended before compare.
  - The lowest-index hitting sprite wins.
  - rgb(next) = 0 if video_active=0; else the winning sprite's colour on a hit; else bg_color.
  - Latency: exactly 1 clk from pix_x/pix_y/video_active to rgb.
- Motion-step updates take effect on the clock edge of the step. A pixel in the same cycle uses the old position.

Test Plan:
- Reset, defaults: after reset, sprite0=(10,7) hue0; sprite1=(13,12) dir_x=0 hue1; rgb=0; corner_count=0. Apply frame_tick and reset together -> state unchanged from reset values.
- Motion and X bounce, defaults: sprite0 position over steps:
  - after 7 ticks, (17,14);
  - 8th tick: y bounce, hue=1, (18,14);
  - 9th tick: (19,13);
  - 10th tick: x bounce, x=19, hue=2, y=12;
  - 11th tick: x=18.
- Corner, GRID_W=GRID_H=16, NUM_SPRITES=1: sprite0 starts (8,8). After 7 ticks it is at (15,15). The 8th tick gives a corner: position unchanged, both dirs=0, corner_hit high for 1 cycle, corner_count=1, hue=1.
- Divider/pause, FRAME_DIV=3: 3 ticks -> one step. With pause=1, 5 ticks -> no motion and the divider holds. Release pause -> the step occurs on the 3rd counted tick.
- Pixel priority/latency: place both sprites on tile (2,1) via the motion sequence. Drive pix_x=64..95, pix_y=32..63, video_active=1 -> rgb one cycle later equals sprite0's colour. Outside that tile -> rgb=bg_color. video_active=0 -> rgb=0.
- Saturation: force 260 corner steps (GRID 2x2, NUM_SPRITES=1) -> corner_count stops at 255; corner_hit still pulses each corner step.

Source files
------------

// File: rtl/bounce_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module  : bounce_sprite_engine
// Brief   : Multi-sprite bouncing-tile renderer with corner counting, 1-clk pixel path.
// Revision: 1.0 - initial release
// ============================================================================
module bounce_sprite_engine #(
  parameter int NUM_SPRITES = 2,
  parameter int TILE_LOG2   = 5,
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int FRAME_DIV   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       video_active,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [5:0] fg_color,
  input  logic [5:0] bg_color,
  output logic [5:0] rgb,
  output logic       corner_hit,
  output logic [7:0] corner_count
);

  localparam int c_XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int c_YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam logic [c_XW-1:0] c_X_MAX = c_XW'(GRID_W - 1);
  localparam logic [c_YW-1:0] c_Y_MAX = c_YW'(GRID_H - 1);
  localparam logic [c_XW-1:0] c_X_ONE = c_XW'(1);
  localparam logic [c_YW-1:0] c_Y_ONE = c_YW'(1);
  localparam logic [7:0]      c_DIV_LAST = 8'(FRAME_DIV - 1);

  logic [7:0]               r_div;
  logic                     w_tick_en;
  logic                     w_step;
  logic [NUM_SPRITES-1:0]   w_corner;
  logic [NUM_SPRITES-1:0]   w_hit;
  logic [NUM_SPRITES*6-1:0] w_color;
  logic [9:0]               w_tx;
  logic [9:0]               w_ty;
  logic [5:0]               w_pix;
  logic [5:0]               r_rgb;
  logic                     r_corner_hit;
  logic [7:0]               r_corner_count;

  assign w_tick_en = frame_tick & ~pause;
  assign w_step    = w_tick_en & (r_div == c_DIV_LAST);
  assign w_tx      = pix_x >> TILE_LOG2;
  assign w_ty      = pix_y >> TILE_LOG2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= 8'd0;
    end else if (w_tick_en) begin
      r_div <= w_step ? 8'd0 : r_div + 8'd1;
    end
  end

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
    localparam logic [c_XW-1:0] c_X0 = c_XW'((GRID_W / 2 + 3 * gi) % GRID_W);
    localparam logic [c_YW-1:0] c_Y0 = c_YW'((GRID_H / 2 + 5 * gi) % GRID_H);

    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic            r_dx;
    logic            r_dy;
    logic [2:0]      r_hue;
    logic            w_bx;
    logic            w_by;

    // A bounce is sitting on the wall we are heading into.
    assign w_bx = r_dx ? (r_x == c_X_MAX) : (r_x == '0);
    assign w_by = r_dy ? (r_y == c_Y_MAX) : (r_y == '0);

    always_ff @(posedge clk) begin
      if (reset) begin
        r_x   <= c_X0;
        r_y   <= c_Y0;
        r_dx  <= (gi % 2 == 0);
        r_dy  <= 1'b1;
        r_hue <= 3'(gi);
      end else if (w_step) begin
        if (w_bx) r_dx <= ~r_dx;
        else      r_x  <= r_dx ? r_x + c_X_ONE : r_x - c_X_ONE;
        if (w_by) r_dy <= ~r_dy;
        else      r_y  <= r_dy ? r_y + c_Y_ONE : r_y - c_Y_ONE;
        if (w_bx | w_by) r_hue <= r_hue + 3'd1;
      end
    end

    assign w_corner[gi]        = w_bx & w_by;
    assign w_hit[gi]           = (w_tx == 10'(r_x)) && (w_ty == 10'(r_y));
    assign w_color[gi*6 +: 6]  = fg_color ^ {r_hue, r_hue};
  end

  // Walk from highest index down so the lowest hitting sprite is written last.
  always_comb begin
    w_pix = bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_pix = w_color[i*6 +: 6];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb          <= 6'd0;
      r_corner_hit   <= 1'b0;
      r_corner_count <= 8'd0;
    end else begin
      r_rgb        <= video_active ? w_pix : 6'd0;
      r_corner_hit <= w_step & (|w_corner);
      if (w_step && (|w_corner) && (r_corner_count != 8'hFF))
        r_corner_count <= r_corner_count + 8'd1;
    end
  end

  assign rgb          = r_rgb;
  assign corner_hit   = r_corner_hit;
  assign corner_count = r_corner_count;

endmodule
`default_nettype wire

// File: tb/tb_bounce_sprite_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_bounce_sprite_engine
// Brief   : Random-stimulus scoreboard bench for two engine configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_bounce_sprite_engine;

  typedef struct packed {
    logic [5:0] rgb;
    logic       hit;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    int x, y, dx, dy, hue;
  } spr_t;

  localparam int P_N [2] = '{2, 3};
  localparam int P_W [2] = '{20, 2};
  localparam int P_H [2] = '{15, 2};
  localparam int P_T [2] = '{5, 1};
  localparam int P_D [2] = '{1, 3};
  localparam int NCYC    = 6000;

  logic             clk = 1'b0;
  logic [1:0]       reset_s, tick_s, pause_s, va_s;
  logic [1:0][9:0]  px_s, py_s;
  logic [1:0][5:0]  fg_s, bg_s, rgb_s;
  logic [1:0]       hit_s;
  logic [1:0][7:0]  cnt_s;

  spr_t m [2][8];
  int   m_div [2];
  int   m_cnt [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always #5 clk = ~clk;

  bounce_sprite_engine u_dut0 (
    .clk(clk), .reset(reset_s[0]), .frame_tick(tick_s[0]), .pause(pause_s[0]),
    .video_active(va_s[0]), .pix_x(px_s[0]), .pix_y(py_s[0]),
    .fg_color(fg_s[0]), .bg_color(bg_s[0]),
    .rgb(rgb_s[0]), .corner_hit(hit_s[0]), .corner_count(cnt_s[0])
  );

  bounce_sprite_engine #(
    .NUM_SPRITES(3), .TILE_LOG2(1), .GRID_W(2), .GRID_H(2), .FRAME_DIV(3)
  ) u_dut1 (
    .clk(clk), .reset(reset_s[1]), .frame_tick(tick_s[1]), .pause(pause_s[1]),
    .video_active(va_s[1]), .pix_x(px_s[1]), .pix_y(py_s[1]),
    .fg_color(fg_s[1]), .bg_color(bg_s[1]),
    .rgb(rgb_s[1]), .corner_hit(hit_s[1]), .corner_count(cnt_s[1])
  );

  // Moves one coordinate one step; returns 1 if it bounced instead.
  function automatic bit axis_step(inout int p, inout int d, input int lim);
    if (d == 1 && p == lim - 1) begin d = 0; return 1'b1; end
    if (d == 0 && p == 0)       begin d = 1; return 1'b1; end
    p = (d == 1) ? p + 1 : p - 1;
    return 1'b0;
  endfunction

  // Reference behaviour for one clock of instance k, given the inputs now driven.
  task automatic model_cycle(input int k, output exp_t e);
    bit step, any, bx, by;
    int win;
    if (reset_s[k]) begin
      for (int i = 0; i < P_N[k]; i++) begin
        m[k][i].x   = (P_W[k] / 2 + 3 * i) % P_W[k];
        m[k][i].y   = (P_H[k] / 2 + 5 * i) % P_H[k];
        m[k][i].dx  = (i % 2 == 0) ? 1 : 0;
        m[k][i].dy  = 1;
        m[k][i].hue = i % 8;
      end
      m_div[k] = 0;
      m_cnt[k] = 0;
      e = '{rgb: 6'd0, hit: 1'b0, cnt: 8'd0};
      return;
    end
    win = -1;
    for (int i = P_N[k] - 1; i >= 0; i--)
      if ((int'(px_s[k]) >> P_T[k]) == m[k][i].x && (int'(py_s[k]) >> P_T[k]) == m[k][i].y)
        win = i;
    if (!va_s[k])     e.rgb = 6'd0;
    else if (win < 0) e.rgb = bg_s[k];
    else              e.rgb = fg_s[k] ^ 6'((m[k][win].hue << 3) | m[k][win].hue);
    step = 1'b0;
    if (tick_s[k] && !pause_s[k]) begin
      step = (m_div[k] == P_D[k] - 1);
      m_div[k] = step ? 0 : m_div[k] + 1;
    end
    any = 1'b0;
    if (step) begin
      for (int i = 0; i < P_N[k]; i++) begin
        bx = axis_step(m[k][i].x, m[k][i].dx, P_W[k]);
        by = axis_step(m[k][i].y, m[k][i].dy, P_H[k]);
        if (bx || by) m[k][i].hue = (m[k][i].hue + 1) % 8;
        if (bx && by) any = 1'b1;
      end
    end
    if (any && m_cnt[k] < 255) m_cnt[k]++;
    e.hit = any;
    e.cnt = 8'(m_cnt[k]);
  endtask

  initial begin
    exp_t e;
    int   j;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        reset_s[k] = (cyc < 3) || (cyc == 40 + 7 * k);
        tick_s[k]  = (cyc < 3) ? 1'b1 : 1'($urandom_range(0, 1));
        pause_s[k] = ($urandom_range(0, 7) == 0);
        va_s[k]    = ($urandom_range(0, 7) != 0);
        fg_s[k]    = 6'($urandom);
        bg_s[k]    = 6'($urandom);
        if ($urandom_range(0, 1) == 1) begin
          j = $urandom_range(0, P_N[k] - 1);
          px_s[k] = 10'((m[k][j].x << P_T[k]) + $urandom_range(0, (1 << P_T[k]) - 1));
          py_s[k] = 10'((m[k][j].y << P_T[k]) + $urandom_range(0, (1 << P_T[k]) - 1));
        end else begin
          px_s[k] = 10'($urandom);
          py_s[k] = 10'($urandom);
        end
        model_cycle(k, e);
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
      @(negedge clk);
    end
    for (int w = 0; w < 10 && (q0.size() != 0 || q1.size() != 0); w++) @(negedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL drain: q0=%0d q1=%0d entries left, required 0", q0.size(), q1.size());
    end
    checks++;
    if (cnt_s[1] !== 8'd255) begin
      failures++;
      $display("FAIL saturate: corner_count=%0d required 255", cnt_s[1]);
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if ((k == 0 ? q0.size() : q1.size()) != 0 && !done) begin
          e = (k == 0) ? q0.pop_front() : q1.pop_front();
          checks++;
          if (rgb_s[k] !== e.rgb) begin
            failures++;
            $display("FAIL rgb inst%0d t=%0t: got %h required %h", k, $time, rgb_s[k], e.rgb);
          end
          checks++;
          if (hit_s[k] !== e.hit) begin
            failures++;
            $display("FAIL corner_hit inst%0d t=%0t: got %b required %b", k, $time, hit_s[k], e.hit);
          end
          checks++;
          if (cnt_s[k] !== e.cnt) begin
            failures++;
            $display("FAIL corner_count inst%0d t=%0t: got %0d required %0d", k, $time, cnt_s[k], e.cnt);
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
